segment_engine_arbiter: RTL and testbench

Round-robin scheduler that shares one if/else segment engine (a fixed-latency block computing `segment_combine` from `input_bit`, `array_ref_wire` and `array_ref_m_wire`) among several requesters. It sits between the requesting stages and a single engine instance:
- Grants one requester per cycle and registers its operands onto the engine.
- Tracks in-flight operations with a tag pipeline.
- Returns tagged results through a credit-protected response FIFO, so the engine never has to stall.

---
 rtl/segment_engine_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_segment_engine_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_engine_arbiter.sv
// segment_engine_arbiter
//   Round-robin scheduler that shares one fixed-latency if/else segment engine
//   among NUM_REQ requesters. One request is granted per cycle, its operands are
//   registered onto the engine, a tag pipeline follows the operation through the
//   engine, and the tagged result lands in a show-ahead response FIFO. A credit
//   counter bounds outstanding work to the FIFO depth, so the engine never stalls.
//
// Ports
//   clk, reset (async, active-low)
//   req_valid/req_ready            per-requester handshake (ready is combinational)
//   req_input_bit/if_ref/else_ref  packed operands, requester i at [i*WIDTH +: WIDTH]
//   eng_issue, eng_*               registered operands to the engine
//   eng_result                     engine output, valid LAT cycles after eng_issue
//   rsp_valid/rsp_id/rsp_data      FIFO head (show-ahead), popped on rsp_ready
//   busy                           high while any accepted operation is not yet popped

// Simulation-only checks on internal invariants of the arbiter.
module segment_engine_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               reset,
  input logic               i_push,
  input logic               i_full,
  input logic [NUM_REQ-1:0] i_req_ready
);

  // The credit counter makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(i_push && i_full));

  // Only one requester may be granted per cycle.
  a_one_grant: assert property (@(posedge clk) disable iff (!reset) $onehot0(i_req_ready));

endmodule

module segment_engine_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int LAT       = 2,
  parameter int RSP_DEPTH = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_input_bit,
  input  logic [NUM_REQ*WIDTH-1:0] req_if_ref,
  input  logic [NUM_REQ*WIDTH-1:0] req_else_ref,
  output logic                     eng_issue,
  output logic [WIDTH-1:0]         eng_input_bit,
  output logic [WIDTH-1:0]         eng_if_ref,
  output logic [WIDTH-1:0]         eng_else_ref,
  input  logic [WIDTH-1:0]         eng_result,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // Advance a FIFO pointer with wrap at RSP_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_ptr_next;
  logic [ID_W:0]    w_idx;
  logic             w_any;
  logic             w_can_issue;
  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic             w_fifo_full;
  logic [CNT_W-1:0] r_credits;
  logic [ID_W-1:0]  r_eng_id;

  logic             r_tag_v  [LAT];
  logic [ID_W-1:0]  r_tag_id [LAT];

  logic [ID_W-1:0]  r_fifo_id   [RSP_DEPTH];
  logic [WIDTH-1:0] r_fifo_data [RSP_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;

  // Round-robin search: walk offsets from farthest to nearest so the requester
  // closest to r_ptr (in wrap order) overwrites any earlier candidate.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      end else begin
        w_idx = w_idx;
      end
      if (req_valid[w_idx[ID_W-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end else begin
        w_any    = w_any;
        w_winner = w_winner;
      end
    end
  end

  // Credits are judged on the registered count only, so a same-cycle pop cannot
  // unlock an accept; reset forces the grant low asynchronously.
  assign w_can_issue = (r_credits < CNT_W'(RSP_DEPTH));
  assign w_accept    = reset & w_can_issue & w_any;
  assign w_ptr_next  = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : (w_winner + ID_W'(1));
  assign w_pop       = rsp_valid & rsp_ready;
  assign w_push      = r_tag_v[LAT-1];
  assign w_fifo_full = (r_count == CNT_W'(RSP_DEPTH));

  // One-hot grant to the round-robin winner when a credit is available.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_winner] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Priority pointer moves past the granted requester only on an accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_next;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Outstanding-operation counter: accepted but not yet popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credits <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits + CNT_W'(1);
        2'b01:   r_credits <= r_credits - CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Issue stage: register the winner's operands and id for the engine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_issue     <= 1'b0;
      eng_input_bit <= '0;
      eng_if_ref    <= '0;
      eng_else_ref  <= '0;
      r_eng_id      <= '0;
    end else if (w_accept) begin
      eng_issue     <= 1'b1;
      eng_input_bit <= req_input_bit[w_winner*WIDTH +: WIDTH];
      eng_if_ref    <= req_if_ref[w_winner*WIDTH +: WIDTH];
      eng_else_ref  <= req_else_ref[w_winner*WIDTH +: WIDTH];
      r_eng_id      <= w_winner;
    end else begin
      eng_issue     <= 1'b0;
    end
  end

  // Tag pipeline mirrors the engine latency; the last stage marks eng_result valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LAT; k++) begin
        r_tag_v[k]  <= 1'b0;
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_v[0]  <= eng_issue;
      r_tag_id[0] <= r_eng_id;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // Response FIFO storage; payload is not reset because the head is gated by rsp_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr]   <= r_tag_id[LAT-1];
      r_fifo_data[r_wr] <= eng_result;
    end else begin
      r_fifo_id[r_wr]   <= r_fifo_id[r_wr];
      r_fifo_data[r_wr] <= r_fifo_data[r_wr];
    end
  end

  // Response FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr <= w_push ? wrap_inc(r_wr) : r_wr;
      r_rd <= w_pop  ? wrap_inc(r_rd) : r_rd;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid = (r_count != '0);
  assign rsp_id    = rsp_valid ? r_fifo_id[r_rd]   : '0;
  assign rsp_data  = rsp_valid ? r_fifo_data[r_rd] : '0;
  assign busy      = (r_credits != '0);

  segment_engine_arbiter_chk #(
    .NUM_REQ (NUM_REQ)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_full      (w_fifo_full),
    .i_req_ready (req_ready)
  );

endmodule

// File: tb/tb_segment_engine_arbiter.sv
// Testbench for segment_engine_arbiter: an if/else engine model with LAT cycles of
// latency, a transaction-level reference (pointer, credit count, queue of expected
// responses with arrival cycles), directed scenarios with literal expectations and
// a randomized traffic phase.
module tb_segment_engine_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int LAT  = 2;
  localparam int D    = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_input_bit;
  logic [N*W-1:0]     req_if_ref;
  logic [N*W-1:0]     req_else_ref;
  logic               eng_issue;
  logic [W-1:0]       eng_input_bit;
  logic [W-1:0]       eng_if_ref;
  logic [W-1:0]       eng_else_ref;
  logic [W-1:0]       eng_result;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_data;
  logic               rsp_ready;
  logic               busy;

  segment_engine_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .LAT       (LAT),
    .RSP_DEPTH (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_input_bit (req_input_bit),
    .req_if_ref    (req_if_ref),
    .req_else_ref  (req_else_ref),
    .eng_issue     (eng_issue),
    .eng_input_bit (eng_input_bit),
    .eng_if_ref    (eng_if_ref),
    .eng_else_ref  (eng_else_ref),
    .eng_result    (eng_result),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Engine: select if/else operand, delivered LAT cycles after the issue cycle.
  logic [W-1:0] eng_pipe [LAT];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LAT; k++) eng_pipe[k] <= '0;
    end else begin
      eng_pipe[0] <= (eng_input_bit != '0) ? eng_if_ref : eng_else_ref;
      for (int k = 1; k < LAT; k++) eng_pipe[k] <= eng_pipe[k-1];
    end
  end
  assign eng_result = eng_pipe[LAT-1];

  // Reference model state.
  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    int             arr;
  } rsp_t;

  rsp_t         q[$];
  int           m_ptr;
  int           m_credits;
  bit           m_issue;
  logic [W-1:0] m_in, m_if, m_else;
  int           cyc;
  int           n_chk;
  int           n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int win();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_clear();
    q.delete();
    m_ptr     = 0;
    m_credits = 0;
    m_issue   = 1'b0;
    m_in      = '0;
    m_if      = '0;
    m_else    = '0;
  endfunction

  // One clock cycle: settle, compare every output against the model, advance model.
  task automatic step();
    int           w;
    logic [N-1:0] er;
    bit           ev, acc, pop;
    rsp_t         e;
    #1;
    if (!reset) model_clear();
    w  = win();
    er = '0;
    if (reset && m_credits < D && w >= 0) er[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("eng_issue", 64'(eng_issue), 64'(m_issue));
    chk("eng_input_bit", 64'(eng_input_bit), 64'(m_in));
    chk("eng_if_ref", 64'(eng_if_ref), 64'(m_if));
    chk("eng_else_ref", 64'(eng_else_ref), 64'(m_else));
    ev = reset && (q.size() > 0) && (q[0].arr <= cyc);
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
    end
    chk("busy", 64'(busy), 64'(m_credits != 0));
    if (reset) begin
      acc = (er != '0);
      pop = ev && rsp_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        m_in   = req_input_bit[w*W +: W];
        m_if   = req_if_ref[w*W +: W];
        m_else = req_else_ref[w*W +: W];
        e.id   = IDW'(w);
        e.data = (m_in != '0) ? m_if : m_else;
        e.arr  = cyc + 2 + LAT;
        q.push_back(e);
        m_ptr   = (w + 1) % N;
        m_issue = 1'b1;
      end else begin
        m_issue = 1'b0;
      end
      m_credits = m_credits + int'(acc) - int'(pop);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < N; i++) begin
      req_input_bit[i*W +: W] = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
      req_if_ref[i*W +: W]    = W'($urandom);
      req_else_ref[i*W +: W]  = W'($urandom);
    end
  endtask

  int acc_cnt;
  int vd, rd;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    model_clear();
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_input_bit = '0; req_if_ref = '0; req_else_ref = '0;
    @(negedge clk);
    step();
    #1;
    chk("lit_reset_busy", 64'(busy), 64'd0);
    chk("lit_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    reset = 1'b1;
    step();

    // Single request from requester 2.
    req_valid = 4'b0100;
    req_input_bit[2*W +: W] = 32'h0000_0001;
    req_if_ref[2*W +: W]    = 32'hA5A5_0001;
    req_else_ref[2*W +: W]  = 32'h5A5A_0002;
    #1 chk("lit_single_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b0000;
    #1;
    chk("lit_single_issue", 64'(eng_issue), 64'd1);
    chk("lit_single_if", 64'(eng_if_ref), 64'hA5A5_0001);
    step();
    step();
    #1 chk("lit_single_not_yet", 64'(rsp_valid), 64'd0);
    step();
    #1;
    chk("lit_single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("lit_single_rsp_id", 64'(rsp_id), 64'd2);
    chk("lit_single_rsp_data", 64'(rsp_data), 64'hA5A5_0001);
    rsp_ready = 1'b1;
    step();

    // All four requesters held valid from ptr=0.
    do_reset();
    randomize_operands();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("lit_rr_grant", 64'(req_ready), 64'(1 << k));
      step();
    end
    for (int k = 0; k < 10; k++) step();
    req_valid = '0;
    for (int k = 0; k < 8; k++) step();

    // Fairness: grant 2, then 3 and 1 compete -> 3 first, then 1.
    do_reset();
    req_valid = 4'b0100;
    #1 chk("lit_fair_2", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b1010;
    #1 chk("lit_fair_3", 64'(req_ready), 64'h8);
    step();
    #1 chk("lit_fair_1", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    for (int k = 0; k < 8; k++) step();

    // Backpressure: requester 0 held, no pops.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    acc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1 if (req_ready[0]) acc_cnt++;
      step();
    end
    chk("lit_bp_accepts", 64'(acc_cnt), 64'd4);
    #1 chk("lit_bp_blocked", 64'(req_ready), 64'h0);
    rsp_ready = 1'b1;
    #1;
    chk("lit_full_pop_id", 64'(rsp_id), 64'd0);
    chk("lit_full_pop_noacc", 64'(req_ready), 64'h0);
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1 chk("lit_resume_grant", 64'(req_ready), 64'h2);
    step();
    #1 chk("lit_full_again", 64'(req_ready), 64'h0);
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();

    // Reset with 3 in flight and 1 buffered.
    do_reset();
    randomize_operands();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) step();
    #2 reset = 1'b0;
    #1;
    chk("lit_mid_rst_ready", 64'(req_ready), 64'h0);
    chk("lit_mid_rst_issue", 64'(eng_issue), 64'd0);
    chk("lit_mid_rst_if", 64'(eng_if_ref), 64'd0);
    chk("lit_mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("lit_mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("lit_mid_rst_busy", 64'(busy), 64'd0);
    step();
    step();
    reset = 1'b1;
    req_valid = 4'b0110;
    #1;
    chk("lit_post_rst_grant", 64'(req_ready), 64'h2);
    chk("lit_post_rst_busy", 64'(busy), 64'd0);
    step();
    req_valid = '0;
    for (int k = 0; k < 6; k++) step();

    // Randomized traffic with varying request and pop densities.
    for (int p = 0; p < 4; p++) begin
      vd = 20 + 25 * p;
      rd = 90 - 25 * p;
      for (int k = 0; k < 500; k++) begin
        for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 99) < vd);
        rsp_ready = ($urandom_range(0, 99) < rd);
        randomize_operands();
        reset = ($urandom_range(0, 399) != 0);
        step();
        reset = 1'b1;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
